amm_mem_responder: RTL and testbench



---
 rtl/rtl_settings_pkg.sv | 18 +
 rtl/amm_resp_ram.sv | 36 +++
 rtl/amm_mem_responder.sv | 181 ++++++++++++++++++
 tb/tb_amm_mem_responder.sv | 316 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/rtl_settings_pkg.sv
// Shared Avalon-MM bus widths and the memory-responder state/limit definitions.
package rtl_settings_pkg;

    localparam int unsigned AMM_ADDR_W  = 32;
    localparam int unsigned AMM_DATA_W  = 32;
    localparam int unsigned AMM_BURST_W = 8;
    localparam int unsigned DATA_B_W    = AMM_DATA_W / 8;

    localparam int unsigned RESP_MAX_RD_LATENCY = 15;

    typedef enum logic [1:0] {
        IDLE,
        WR_BURST,
        RD_WAIT,
        RD_BURST
    } resp_state_t;

endpackage

// File: rtl/amm_resp_ram.sv
// Byte-enabled single-port RAM with a registered read port; flip inverts bit 0 of the captured word.
module amm_resp_ram #(
    parameter int unsigned ADDR_W = 10,
    parameter int unsigned DATA_W = 32,
    parameter int unsigned BE_W   = DATA_W / 8
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              we,
    input  logic              re,
    input  logic              flip,
    input  logic [ADDR_W-1:0] addr,
    input  logic [DATA_W-1:0] wdata,
    input  logic [BE_W-1:0]   be,
    output logic [DATA_W-1:0] q
);

    localparam int unsigned DEPTH = 1 << ADDR_W;

    logic [DATA_W-1:0] mem [DEPTH];

    // Storage is deliberately not reset so contents survive a bus reset.
    always_ff @(posedge clk) begin
        if (we) begin
            for (int b = 0; b < int'(BE_W); b++) begin
                if (be[b]) mem[addr][b*8 +: 8] <= wdata[b*8 +: 8];
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) q <= '0;
        else if (re) q <= mem[addr] ^ DATA_W'(flip);
    end

endmodule

// File: rtl/amm_mem_responder.sv
// Avalon-MM slave memory responder: burst writes/reads into a local RAM with fixed read latency.
// Optional read error injection is enabled by defining AMM_RESP_ERR_INJ_EN.
module amm_mem_responder
    import rtl_settings_pkg::*;
#(
    parameter int unsigned MEM_ADDR_W      = 10,
    parameter int unsigned RD_LATENCY      = 4,
    parameter int unsigned WR_STALL_PERIOD = 0
) (
    input  logic                   clk_i,
    input  logic                   rst_i,
    input  logic [AMM_ADDR_W-1:0]  address_i,
    input  logic                   read_i,
    input  logic                   write_i,
    input  logic [AMM_DATA_W-1:0]  writedata_i,
    input  logic [AMM_BURST_W-1:0] burstcount_i,
    input  logic [DATA_B_W-1:0]    byteenable_i,
`ifdef AMM_RESP_ERR_INJ_EN
    input  logic                   inj_en_i,
    input  logic [MEM_ADDR_W-1:0]  inj_addr_i,
`endif
    output logic                   waitrequest_o,
    output logic                   readdatavalid_o,
    output logic [AMM_DATA_W-1:0]  readdata_o,
    output logic                   proto_err_o
);

    localparam int unsigned BC_W    = AMM_BURST_W;
    localparam int unsigned LAT_W   = $clog2(RESP_MAX_RD_LATENCY + 1);
    localparam int unsigned STALL_W = 16;

    resp_state_t            state_q, state_d;
    logic [MEM_ADDR_W-1:0]  base_q, base_d;
    logic [BC_W-1:0]        len_q, len_d;
    logic [BC_W-1:0]        beat_q, beat_d;
    logic [LAT_W-1:0]       lat_q, lat_d;
    logic [STALL_W-1:0]     wr_cnt_q, wr_cnt_d;
    logic                   err_d, rvalid_d, wait_d, stall;
    logic                   ram_we, ram_re, ram_flip;
    logic [MEM_ADDR_W-1:0]  ram_addr;

    logic                   wr_acc, rd_acc, bc_zero, unused_addr_hi;
    logic [MEM_ADDR_W-1:0]  req_addr;
    logic [BC_W-1:0]        req_len;

    assign wr_acc         = write_i & ~waitrequest_o;
    assign rd_acc         = read_i & ~waitrequest_o;
    assign bc_zero        = (burstcount_i == '0);
    assign req_len        = bc_zero ? BC_W'(1) : burstcount_i;
    assign req_addr       = address_i[MEM_ADDR_W-1:0];
    assign unused_addr_hi = ^address_i;

    // Next-state, RAM control and stall decision.
    always_comb begin
        state_d  = state_q;
        base_d   = base_q;
        len_d    = len_q;
        beat_d   = beat_q;
        lat_d    = lat_q;
        wr_cnt_d = wr_cnt_q;
        err_d    = proto_err_o;
        rvalid_d = 1'b0;
        stall    = 1'b0;
        ram_we   = 1'b0;
        ram_re   = 1'b0;
        ram_addr = base_q + MEM_ADDR_W'(beat_q);

        unique case (state_q)
            IDLE: begin
                if (wr_acc) begin
                    ram_we   = 1'b1;
                    ram_addr = req_addr;
                    base_d   = req_addr;
                    len_d    = req_len;
                    beat_d   = BC_W'(1);
                    if (bc_zero || read_i) err_d = 1'b1;
                    if (req_len != BC_W'(1)) state_d = WR_BURST;
                end else if (rd_acc) begin
                    base_d = req_addr;
                    len_d  = req_len;
                    beat_d = '0;
                    if (bc_zero) err_d = 1'b1;
                    // Latency 1 issues the first RAM read on the acceptance edge itself.
                    if (RD_LATENCY <= 1) begin
                        ram_re   = 1'b1;
                        ram_addr = req_addr;
                        rvalid_d = 1'b1;
                        beat_d   = BC_W'(1);
                        if (req_len != BC_W'(1)) state_d = RD_BURST;
                    end else begin
                        lat_d   = LAT_W'(RD_LATENCY - 1);
                        state_d = RD_WAIT;
                    end
                end
            end
            WR_BURST: begin
                if (read_i) err_d = 1'b1;
                if (wr_acc) begin
                    ram_we = 1'b1;
                    beat_d = beat_q + BC_W'(1);
                    if (beat_q == len_q - BC_W'(1)) state_d = IDLE;
                end
            end
            RD_WAIT: begin
                lat_d = lat_q - LAT_W'(1);
                if (lat_q == LAT_W'(1)) begin
                    ram_re   = 1'b1;
                    rvalid_d = 1'b1;
                    beat_d   = beat_q + BC_W'(1);
                    state_d  = (len_q == BC_W'(1)) ? IDLE : RD_BURST;
                end
            end
            RD_BURST: begin
                ram_re   = 1'b1;
                rvalid_d = 1'b1;
                beat_d   = beat_q + BC_W'(1);
                if (beat_q == len_q - BC_W'(1)) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase

        if (WR_STALL_PERIOD != 0 && wr_acc) begin
            if (wr_cnt_q == STALL_W'(WR_STALL_PERIOD - 1)) begin
                wr_cnt_d = '0;
                stall    = 1'b1;
            end else begin
                wr_cnt_d = wr_cnt_q + STALL_W'(1);
            end
        end

        // waitrequest falls in the cycle carrying the last read beat.
        wait_d = stall | (state_d == RD_WAIT) | (state_d == RD_BURST);
    end

`ifdef AMM_RESP_ERR_INJ_EN
    assign ram_flip = inj_en_i & (ram_addr == inj_addr_i);
`else
    assign ram_flip = 1'b0;
`endif

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q         <= IDLE;
            base_q          <= '0;
            len_q           <= '0;
            beat_q          <= '0;
            lat_q           <= '0;
            wr_cnt_q        <= '0;
            waitrequest_o   <= 1'b0;
            readdatavalid_o <= 1'b0;
            proto_err_o     <= 1'b0;
        end else begin
            state_q         <= state_d;
            base_q          <= base_d;
            len_q           <= len_d;
            beat_q          <= beat_d;
            lat_q           <= lat_d;
            wr_cnt_q        <= wr_cnt_d;
            waitrequest_o   <= wait_d;
            readdatavalid_o <= rvalid_d;
            proto_err_o     <= err_d;
        end
    end

    amm_resp_ram #(
        .ADDR_W (MEM_ADDR_W),
        .DATA_W (AMM_DATA_W),
        .BE_W   (DATA_B_W)
    ) u_ram (
        .clk   (clk_i),
        .rst   (rst_i),
        .we    (ram_we),
        .re    (ram_re),
        .flip  (ram_flip),
        .addr  (ram_addr),
        .wdata (writedata_i),
        .be    (byteenable_i),
        .q     (readdata_o)
    );

endmodule

// File: tb/tb_amm_mem_responder.sv
// Self-checking bench for amm_mem_responder against a cycle-level behavioural memory model.
module tb_amm_mem_responder;
    import rtl_settings_pkg::AMM_ADDR_W;
    import rtl_settings_pkg::AMM_DATA_W;
    import rtl_settings_pkg::AMM_BURST_W;
    import rtl_settings_pkg::DATA_B_W;

    localparam int unsigned MEM_ADDR_W = 10;
    localparam int unsigned LAT        = 4;
    localparam int unsigned STALL_N    = 3;
    localparam int unsigned DEPTH      = 1 << MEM_ADDR_W;

    logic                   clk = 1'b0;
    logic                   rst_i;
    logic [AMM_ADDR_W-1:0]  address_i;
    logic                   read_i, write_i;
    logic [AMM_DATA_W-1:0]  writedata_i;
    logic [AMM_BURST_W-1:0] burstcount_i;
    logic [DATA_B_W-1:0]    byteenable_i;
    logic                   waitrequest_o, readdatavalid_o, proto_err_o;
    logic [AMM_DATA_W-1:0]  readdata_o;
`ifdef AMM_RESP_ERR_INJ_EN
    logic                   inj_en_i = 1'b0;
    logic [MEM_ADDR_W-1:0]  inj_addr_i = '0;
`endif

    amm_mem_responder #(
        .MEM_ADDR_W      (MEM_ADDR_W),
        .RD_LATENCY      (LAT),
        .WR_STALL_PERIOD (STALL_N)
    ) dut (
        .clk_i           (clk),
        .rst_i           (rst_i),
        .address_i       (address_i),
        .read_i          (read_i),
        .write_i         (write_i),
        .writedata_i     (writedata_i),
        .burstcount_i    (burstcount_i),
        .byteenable_i    (byteenable_i),
`ifdef AMM_RESP_ERR_INJ_EN
        .inj_en_i        (inj_en_i),
        .inj_addr_i      (inj_addr_i),
`endif
        .waitrequest_o   (waitrequest_o),
        .readdatavalid_o (readdatavalid_o),
        .readdata_o      (readdata_o),
        .proto_err_o     (proto_err_o)
    );

    always #5 clk = ~clk;

    int errors = 0;
    int checks = 0;

    // Reference model: memory image, expected stall/error flags, accepted-write counter.
    logic [31:0] mm [DEPTH];
    bit          exp_wait, exp_err;
    int          wcnt;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic model_reset();
        exp_wait = 0;
        exp_err  = 0;
        wcnt     = 0;
    endtask

    task automatic model_write_beat(input int unsigned idx, input logic [31:0] d, input logic [3:0] be);
        for (int b = 0; b < 4; b++) if (be[b]) mm[idx][b*8 +: 8] = d[b*8 +: 8];
        wcnt++;
        if (wcnt == int'(STALL_N)) begin
            wcnt = 0;
            exp_wait = 1;
        end else begin
            exp_wait = 0;
        end
    endtask

    task automatic idle_cycle();
        read_i = 0; write_i = 0;
        checks++;
        if (waitrequest_o !== exp_wait) begin
            errors++;
            $display("FAIL idle_wait: got %b expected %b", waitrequest_o, exp_wait);
        end
        step();
        exp_wait = 0;
    endtask

    task automatic do_reset();
        read_i = 0; write_i = 0;
        rst_i = 1;
        step();
        step();
        rst_i = 0;
        model_reset();
    endtask

    // mode 0: constant val, 1: beat index, 2: random. len is the raw burstcount presented.
    task automatic do_write(input int unsigned addr, input int unsigned len, input int mode,
                            input logic [31:0] val, input logic [3:0] be, input bit gaps);
        int unsigned bc = (len == 0) ? 1 : len;
        int unsigned n = 0;
        logic [31:0] d;
        bit acc;
        while (n < bc) begin
            if (gaps && n != 0 && $urandom_range(0, 3) == 0) begin
                idle_cycle();
                continue;
            end
            d = (mode == 0) ? val : (mode == 1) ? 32'(n) : $urandom;
            write_i      = 1;
            read_i       = 0;
            address_i    = (n == 0) ? 32'(addr) : $urandom;
            writedata_i  = d;
            byteenable_i = be;
            burstcount_i = (n == 0) ? 8'(len) : 8'($urandom);
            checks++;
            if (waitrequest_o !== exp_wait) begin
                errors++;
                $display("FAIL wr_wait beat %0d: got %b expected %b", n, waitrequest_o, exp_wait);
            end
            acc = !exp_wait;
            step();
            if (acc) begin
                model_write_beat((addr + n) % DEPTH, d, be);
                if (len == 0) exp_err = 1;
                n++;
            end else begin
                exp_wait = 0;
            end
        end
        write_i = 0;
    endtask

    // rst_after > 0 pulses reset right after that many read beats have been seen.
    task automatic do_read(input int unsigned addr, input int unsigned len, input int rst_after);
        int unsigned bc = (len == 0) ? 1 : len;
        int beats = 0;
        bit ev, ew;
        if (exp_wait) idle_cycle();
        read_i       = 1;
        write_i      = 0;
        address_i    = 32'(addr);
        burstcount_i = 8'(len);
        writedata_i  = $urandom;
        byteenable_i = 4'($urandom);
        checks++;
        if (waitrequest_o !== 1'b0) begin
            errors++;
            $display("FAIL rd_accept_wait: got %b expected 0", waitrequest_o);
        end
        step();
        if (len == 0) exp_err = 1;
        read_i       = 0;
        address_i    = $urandom;
        burstcount_i = 8'($urandom);
        for (int k = 1; k <= int'(LAT + bc); k++) begin
            ev = (k >= int'(LAT)) && (k < int'(LAT + bc));
            ew = (k < int'(LAT + bc) - 1);
            checks++;
            if (readdatavalid_o !== ev) begin
                errors++;
                $display("FAIL rd_valid cyc %0d: got %b expected %b", k, readdatavalid_o, ev);
            end
            checks++;
            if (waitrequest_o !== ew) begin
                errors++;
                $display("FAIL rd_wait cyc %0d: got %b expected %b", k, waitrequest_o, ew);
            end
            if (ev) begin
                checks++;
                if (readdata_o !== mm[(addr + k - LAT) % DEPTH]) begin
                    errors++;
                    $display("FAIL rd_data idx %0h: got %h expected %h", (addr + k - LAT) % DEPTH,
                             readdata_o, mm[(addr + k - LAT) % DEPTH]);
                end
                beats++;
            end
            if (rst_after > 0 && beats == rst_after) begin
                rst_i = 1;
                #1;
                checks++;
                if (readdatavalid_o !== 1'b0) begin
                    errors++;
                    $display("FAIL rst_rvalid: got %b expected 0", readdatavalid_o);
                end
                checks++;
                if (waitrequest_o !== 1'b0) begin
                    errors++;
                    $display("FAIL rst_wait: got %b expected 0", waitrequest_o);
                end
                #1;
                rst_i = 0;
                model_reset();
                return;
            end
            step();
        end
        exp_wait = 0;
        checks++;
        if (proto_err_o !== exp_err) begin
            errors++;
            $display("FAIL rd_proto_err: got %b expected %b", proto_err_o, exp_err);
        end
    endtask

    task automatic test_reset();
        do_reset();
        checks += 4;
        if (waitrequest_o !== 1'b0) begin errors++; $display("FAIL reset_wait: got %b expected 0", waitrequest_o); end
        if (readdatavalid_o !== 1'b0) begin errors++; $display("FAIL reset_rvalid: got %b expected 0", readdatavalid_o); end
        if (readdata_o !== 32'h0) begin errors++; $display("FAIL reset_rdata: got %h expected 0", readdata_o); end
        if (proto_err_o !== 1'b0) begin errors++; $display("FAIL reset_err: got %b expected 0", proto_err_o); end
    endtask

    task automatic test_single();
        do_write(32'h10, 1, 0, 32'hA5A5A5A5, 4'hF, 0);
        do_read(32'h10, 1, -1);
    endtask

    task automatic test_wrap();
        do_write(32'h3FC, 8, 1, 32'h0, 4'hF, 1);
        do_read(32'h3FC, 8, -1);
    endtask

    task automatic test_partial();
        do_write(32'h20, 1, 0, 32'h0, 4'hF, 0);
        do_write(32'h20, 1, 0, 32'hFFFFFFFF, 4'h1, 0);
        do_read(32'h20, 1, -1);
    endtask

    task automatic test_stall();
        do_reset();
        do_write(32'h40, 6, 2, 32'h0, 4'hF, 0);
        checks++;
        if (waitrequest_o !== 1'b1) begin
            errors++;
            $display("FAIL stall_after_beat6: got %b expected 1", waitrequest_o);
        end
        do_read(32'h40, 6, -1);
    endtask

    task automatic test_proto_err();
        logic [31:0] d = $urandom;
        do_reset();
        if (exp_wait) idle_cycle();
        read_i = 1; write_i = 1; address_i = 32'h80; writedata_i = d;
        burstcount_i = 8'd1; byteenable_i = 4'hF;
        step();
        model_write_beat(32'h80, d, 4'hF);
        exp_err = 1;
        read_i = 0; write_i = 0;
        for (int k = 1; k <= int'(LAT) + 1; k++) begin
            checks++;
            if (readdatavalid_o !== 1'b0) begin
                errors++;
                $display("FAIL collide_rvalid cyc %0d: got %b expected 0", k, readdatavalid_o);
            end
            checks++;
            if (proto_err_o !== 1'b1) begin
                errors++;
                $display("FAIL collide_err cyc %0d: got %b expected 1", k, proto_err_o);
            end
            step();
            exp_wait = 0;
        end
        do_read(32'h80, 1, -1);
        do_reset();
        checks++;
        if (proto_err_o !== 1'b0) begin
            errors++;
            $display("FAIL err_clear: got %b expected 0", proto_err_o);
        end
        do_write(32'h90, 0, 2, 32'h0, 4'hF, 0);
        do_read(32'h90, 1, -1);
        do_reset();
    endtask

    task automatic test_reset_mid_read();
        do_write(32'h100, 4, 2, 32'h0, 4'hF, 0);
        do_read(32'h100, 4, 2);
        do_read(32'h100, 4, -1);
    endtask

    task automatic test_random();
        int unsigned a, l;
        for (int i = 0; i < 12; i++) begin
            a = $urandom_range(0, DEPTH - 1);
            l = $urandom_range(1, 8);
            do_write(a, l, 2, 32'h0, 4'hF, 1);
            if ($urandom_range(0, 1) == 1) do_write(a, l, 2, 32'h0, 4'($urandom), 1);
            do_read(a, l, -1);
        end
    endtask

    initial begin
        rst_i = 1; read_i = 0; write_i = 0; address_i = '0;
        writedata_i = '0; burstcount_i = '0; byteenable_i = '0;
        model_reset();
        test_reset();
        test_single();
        test_wrap();
        test_partial();
        test_stall();
        test_proto_err();
        test_reset_mid_read();
        test_random();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
